display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning clock cycles each digit is driven per scan slot.
REQ-002 SHALL have parameter BLANK_CYC, default 500, meaning anti-ghosting dead-time cycles before each digit slot.
REQ-003 SHALL have port clk50MHz, in, 1, the single 50 MHz system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, in, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port wr_en, in, 1, write request; held high until wr_ack.
REQ-006 SHALL have port wr_data, in, 16, four BCD nibbles; [3:0] = digit0 (rightmost), [15:12] = digit3.
REQ-007 SHALL have port wr_dp, in, 4, decimal-point enables; bit i = digit i.
REQ-008 SHALL have port lzb_en, in, 1, leading-zero blanking enable; sampled live.
REQ-009 SHALL have port wr_ack, out, 1, one-cycle pulse when the write is captured.
REQ-010 SHALL have port Segments, out, 7, active-low segments; bit0 = a … bit6 = g.
REQ-011 SHALL have port bp, out, 1, active-low decimal point.
REQ-012 SHALL have port AN, out, 4, active-low common-anode digit selects.
REQ-013 SHALL have port frame_done, out, 1, one-cycle pulse at the end of each 4-digit frame.

Function
REQ-014 SHALL register all outputs; no combinational path from any input to any output.
REQ-015 SHALL implement FSM states BLANK and DRIVE, a digit index idx (0..3) and a slot counter of width $clog2(max(DIV,BLANK_CYC)).
REQ-016 BLANK: AN=4'b1111, Segments=7'h7F, bp=1 for BLANK_CYC cycles, then -> DRIVE with the counter cleared.
REQ-017 DRIVE: AN bit idx=0, others 1; Segments/bp from active register digit idx for DIV cycles; then idx wraps as 3->0 and -> BLANK.
REQ-018 Digit period SHALL be BLANK_CYC+DIV cycles and frame period 4*(BLANK_CYC+DIV) cycles, with no jitter.
REQ-019 Decode SHALL give standard active-low 0-9 patterns (0=7'b1000000, 4=7'b0011001, 7=7'b1111000); nibbles 10-15 SHALL give 7'h7F.
REQ-020 With lzb_en=1, digit i (i=3..1) SHALL show 7'h7F when it and all higher digits are 0; digit0 is never blanked; bp is unaffected.
REQ-021 Write path: one-deep pending buffer (data+dp+full flag); when wr_en=1 and pending empty, capture and pulse wr_ack the next cycle.
REQ-022 When pending is full, wr_ack SHALL be withheld (backpressure) until the pending buffer has been transferred.
REQ-023 On the cycle DRIVE ends with idx=3: pulse frame_done, copy pending to active if full, clear full; the display never changes mid-frame.
REQ-024 If wr_en=1 in the transfer cycle, the transfer SHALL take priority and the new write is acknowledged no earlier than the following cycle.
REQ-025 wr_ack SHALL never pulse on two consecutive cycles for one held request; the requester drops wr_en after wr_ack.

Reset
REQ-026 rst=1 SHALL immediately force AN=4'hF, Segments=7'h7F, bp=1, wr_ack=0, frame_done=0, state=BLANK, idx=0, counter=0, active=0, wr_dp store=0, pending empty.
REQ-027 Reset asserted mid-DRIVE or mid-write SHALL abort the operation without an ack; scanning restarts from BLANK/idx0 on release.

Verification (DIV=4, BLANK_CYC=2, frame=24 cycles)
REQ-028 Reset release -> 2 cycles AN=1111; then 4 cycles AN=1110 with Segments=7'b1000000; then BLANK; AN walks 1101, 1011, 0111; frame_done pulses once every 24 cycles.
REQ-029 Hold wr_en with wr_data=16'h1234, wr_dp=4'b0001 -> single wr_ack pulse; old values persist until frame_done; the next frame shows digit0 Segments=7'b0011001, bp=0.
REQ-030 Issue a second write while pending is full -> wr_ack low until the cycle after the transfer; then acknowledged and displayed one frame later.
REQ-031 lzb_en=1, data 16'h0070 -> digits 3 and 2 show 7'h7F, digit1 shows 7'b1111000, digit0 shows 7'b1000000.
REQ-032 Nibble 4'hA in digit1 -> Segments=7'h7F during slot 1; assert rst during DRIVE idx=2 -> outputs reach reset values asynchronously; restart per REQ-028.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Multiplexed four-digit common-anode seven-segment scanner.
// Each digit slot is a dead-time (BLANK) phase followed by a drive (DRIVE) phase.
// New display contents are written through a one-deep pending buffer.
// That buffer is copied to the active register only at a frame boundary,
// so a frame is never torn.
// Every output is a flop. The next-cycle output values are decoded from the
// next-state values, so the outputs line up with the scan state without lag.
module display_scan_ctrl #(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk50MHz,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic        lzb_en,
  output logic        wr_ack,
  output logic [6:0]  Segments,
  output logic        bp,
  output logic [3:0]  AN,
  output logic        frame_done
);

  // The slot counter is sized for the longer of the two phases.
  // It is kept at least one bit wide.
  localparam int MAX_CYC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] CNT_ZERO   = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(DIV - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Active-low segment pattern (bit0 = a ... bit6 = g).
  // Non-BCD nibbles show an unlit digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // Scan state
  state_t        state_r;
  state_t        state_s;
  logic [1:0]    idx_r;
  logic [1:0]    idx_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          frame_end_s;

  // Display contents
  logic [15:0]   active_data_r;
  logic [3:0]    active_dp_r;
  logic [15:0]   pend_data_r;
  logic [3:0]    pend_dp_r;
  logic          pend_full_r;
  logic          capture_s;

  // Next output values and output flops
  logic [3:0]    nib_s;
  logic          lead_zero_s;
  logic [3:0]    an_s;
  logic [6:0]    seg_s;
  logic          bp_s;
  logic [3:0]    an_r;
  logic [6:0]    seg_r;
  logic          bp_r;
  logic          wr_ack_r;
  logic          frame_done_r;

  // Scan state register: phase, digit index and slot counter
  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      state_r <= ST_BLANK;
      idx_r   <= 2'd0;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic.
  // Each phase runs for its full length, then the counter restarts.
  // The digit index advances (3 wraps to 0) as DRIVE ends.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    cnt_s       = cnt_r;
    frame_end_s = 1'b0;
    case (state_r)
      ST_BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_s = ST_DRIVE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DRIVE: begin
        if (cnt_r == DRIVE_LAST) begin
          state_s     = ST_BLANK;
          cnt_s       = CNT_ZERO;
          idx_s       = idx_r + 2'd1;
          frame_end_s = (idx_r == 2'd3);
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_BLANK;
        cnt_s   = CNT_ZERO;
        idx_s   = 2'd0;
      end
    endcase
  end

  // A write is taken only into an empty buffer, and never on the cycle right
  // after an ack. The frame-boundary transfer has priority over a new capture.
  always_comb begin
    capture_s = 1'b0;
    if (wr_en && !pend_full_r && !wr_ack_r && !frame_end_s) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
  end

  // Write path: pending capture with ack pulse, and pending-to-active
  // transfer at frame end
  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      active_data_r <= 16'h0000;
      active_dp_r   <= 4'b0000;
      pend_data_r   <= 16'h0000;
      pend_dp_r     <= 4'b0000;
      pend_full_r   <= 1'b0;
      wr_ack_r      <= 1'b0;
    end else begin
      wr_ack_r <= capture_s;
      if (frame_end_s) begin
        if (pend_full_r) begin
          active_data_r <= pend_data_r;
          active_dp_r   <= pend_dp_r;
        end
        pend_full_r <= 1'b0;
      end else if (capture_s) begin
        pend_data_r <= wr_data;
        pend_dp_r   <= wr_dp;
        pend_full_r <= 1'b1;
      end
    end
  end

  // Select the nibble of the digit about to be driven.
  // Also flag it as a blankable leading zero: that digit and every higher
  // digit are 0. Digit 0 is never blanked.
  always_comb begin
    nib_s       = 4'h0;
    lead_zero_s = 1'b0;
    case (idx_s)
      2'd0: begin
        nib_s       = active_data_r[3:0];
        lead_zero_s = 1'b0;
      end
      2'd1: begin
        nib_s       = active_data_r[7:4];
        lead_zero_s = (active_data_r[15:4] == 12'h000);
      end
      2'd2: begin
        nib_s       = active_data_r[11:8];
        lead_zero_s = (active_data_r[15:8] == 8'h00);
      end
      2'd3: begin
        nib_s       = active_data_r[15:12];
        lead_zero_s = (active_data_r[15:12] == 4'h0);
      end
      default: begin
        nib_s       = 4'h0;
        lead_zero_s = 1'b0;
      end
    endcase
  end

  // Next-cycle anode, segment and decimal-point values.
  // BLANK turns everything off; DRIVE lights only the selected digit.
  always_comb begin
    an_s  = 4'b1111;
    seg_s = 7'h7F;
    bp_s  = 1'b1;
    if (state_s == ST_DRIVE) begin
      an_s = ~(4'b0001 << idx_s);
      if (lzb_en && lead_zero_s) begin
        seg_s = 7'h7F;
      end else begin
        seg_s = seg_decode(nib_s);
      end
      bp_s = ~active_dp_r[idx_s];
    end else begin
      an_s  = 4'b1111;
      seg_s = 7'h7F;
      bp_s  = 1'b1;
    end
  end

  // Output flops: display drive and the frame-boundary pulse
  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      an_r         <= 4'b1111;
      seg_r        <= 7'h7F;
      bp_r         <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      an_r         <= an_s;
      seg_r        <= seg_s;
      bp_r         <= bp_s;
      frame_done_r <= frame_end_s;
    end
  end

  assign AN         = an_r;
  assign Segments   = seg_r;
  assign bp         = bp_r;
  assign frame_done = frame_done_r;
  assign wr_ack     = wr_ack_r;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with DIV=4 and BLANK_CYC=2 (24-cycle frame).
// A cycle-position model predicts every output on every cycle.
// Directed literal checks pin the model.
module tb_display_scan_ctrl;

  localparam int DIV   = 4;
  localparam int BL    = 2;
  localparam int SLOT  = DIV + BL;
  localparam int FRAME = 4 * SLOT;

  logic        clk50MHz = 1'b0;
  logic        rst      = 1'b1;
  logic        wr_en    = 1'b0;
  logic [15:0] wr_data  = 16'h0000;
  logic [3:0]  wr_dp    = 4'b0000;
  logic        lzb_en   = 1'b0;
  logic        wr_ack;
  logic [6:0]  Segments;
  logic        bp;
  logic [3:0]  AN;
  logic        frame_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Standard active-low digit patterns 0..9
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  display_scan_ctrl #(.DIV(DIV), .BLANK_CYC(BL)) dut (
    .clk50MHz  (clk50MHz),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_dp     (wr_dp),
    .lzb_en    (lzb_en),
    .wr_ack    (wr_ack),
    .Segments  (Segments),
    .bp        (bp),
    .AN        (AN),
    .frame_done(frame_done)
  );

  always #10 clk50MHz = ~clk50MHz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: t counts clock edges since reset release, and the scan position
  // follows from t by plain arithmetic. The write buffer is tracked as
  // simple variables.
  initial begin : model
    int          t;
    int          s;
    int          d;
    int          w;
    int          nib;
    bit          fe;
    bit          cap;
    bit          m_full;
    bit          m_ack;
    logic [15:0] m_act;
    logic [15:0] m_pend;
    logic [3:0]  m_act_dp;
    logic [3:0]  m_pend_dp;
    logic        s_rst;
    logic        s_en;
    logic        s_lzb;
    logic [15:0] s_d;
    logic [3:0]  s_dp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_bp;
    logic        e_fd;
    t = 0; m_full = 1'b0; m_ack = 1'b0;
    m_act = 16'h0; m_pend = 16'h0; m_act_dp = 4'h0; m_pend_dp = 4'h0;
    forever begin
      @(posedge clk50MHz);
      s_rst = rst; s_en = wr_en; s_lzb = lzb_en; s_d = wr_data; s_dp = wr_dp;
      if (s_rst) begin
        t = 0; m_full = 1'b0; m_ack = 1'b0; m_act = 16'h0; m_act_dp = 4'h0;
      end else begin
        fe  = ((t % FRAME) == FRAME - 1);
        cap = s_en && !m_full && !m_ack && !fe;
        if (fe && m_full) begin
          m_act = m_pend; m_act_dp = m_pend_dp;
        end
        if (fe) m_full = 1'b0;
        if (cap) begin
          m_pend = s_d; m_pend_dp = s_dp; m_full = 1'b1;
        end
        m_ack = cap;
        t++;
      end
      s = t % FRAME; d = s / SLOT; w = s % SLOT;
      if (w < BL) begin
        e_an = 4'hF; e_seg = 7'h7F; e_bp = 1'b1;
      end else begin
        e_an = 4'hF ^ (4'h1 << d);
        nib  = int'((m_act >> (4 * d)) & 16'h000F);
        e_seg = (nib > 9) ? 7'h7F : seg_tab[nib];
        if (s_lzb && d > 0 && (m_act >> (4 * d)) == 16'h0) e_seg = 7'h7F;
        e_bp = ~m_act_dp[d];
      end
      e_fd = (t > 0) && (s == 0);
      #1;
      chk("model_AN", AN, e_an);
      chk("model_Segments", Segments, e_seg);
      chk("model_bp", bp, e_bp);
      chk("model_frame_done", frame_done, e_fd);
      chk("model_wr_ack", wr_ack, m_ack);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk50MHz);
    #2;
  endtask

  // Directed stimulus with hand-computed expectations (t = edges since release)
  initial begin
    step(3);
    chk("rst_AN", AN, 4'hF); chk("rst_Segments", Segments, 7'h7F);
    chk("rst_bp", bp, 1'b1); chk("rst_wr_ack", wr_ack, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    rst = 1'b0;
    step(1);  chk("t1_AN", AN, 4'hF);
    step(1);  chk("t2_AN", AN, 4'hE); chk("t2_Segments", Segments, 7'b1000000);
    step(4);  chk("t6_AN", AN, 4'hF);
    step(2);  chk("t8_AN", AN, 4'hD);
    step(6);  chk("t14_AN", AN, 4'hB);
    step(6);  chk("t20_AN", AN, 4'h7);
    step(3);  chk("t23_frame_done", frame_done, 1'b0);
    step(1);  chk("t24_frame_done", frame_done, 1'b1); chk("t24_AN", AN, 4'hF);
    step(1);  chk("t25_frame_done", frame_done, 1'b0);
    wr_en = 1'b1; wr_data = 16'h1234; wr_dp = 4'b0001;
    step(1);  chk("t26_wr_ack", wr_ack, 1'b1);
    chk("t26_old_Segments", Segments, 7'b1000000); chk("t26_old_bp", bp, 1'b1);
    wr_en = 1'b0;
    step(1);  chk("t27_wr_ack", wr_ack, 1'b0);
    wr_en = 1'b1; wr_data = 16'h5678; wr_dp = 4'b0000;
    step(21); chk("t48_backpressure", wr_ack, 1'b0); chk("t48_frame_done", frame_done, 1'b1);
    step(1);  chk("t49_wr_ack", wr_ack, 1'b1);
    wr_en = 1'b0;
    step(1);  chk("t50_AN", AN, 4'hE); chk("t50_Segments", Segments, 7'b0011001);
    chk("t50_bp", bp, 1'b0);
    wr_en = 1'b1; wr_data = 16'h0070; wr_dp = 4'b0100; lzb_en = 1'b1;
    step(22); chk("t72_backpressure", wr_ack, 1'b0);
    step(1);  chk("t73_wr_ack", wr_ack, 1'b1);
    wr_en = 1'b0;
    step(1);  chk("t74_Segments", Segments, 7'b0000000); chk("t74_bp", bp, 1'b1);
    step(24); chk("lzb_d0_AN", AN, 4'hE); chk("lzb_d0_Segments", Segments, 7'b1000000);
    step(6);  chk("lzb_d1_AN", AN, 4'hD); chk("lzb_d1_Segments", Segments, 7'b1111000);
    step(6);  chk("lzb_d2_AN", AN, 4'hB); chk("lzb_d2_Segments", Segments, 7'h7F);
    chk("lzb_d2_bp", bp, 1'b0);
    step(6);  chk("lzb_d3_AN", AN, 4'h7); chk("lzb_d3_Segments", Segments, 7'h7F);
    lzb_en = 1'b0; wr_en = 1'b1; wr_data = 16'h00A0; wr_dp = 4'b0000;
    step(1);  chk("t117_wr_ack", wr_ack, 1'b1);
    wr_en = 1'b0;
    step(11); chk("hexA_AN", AN, 4'hD); chk("hexA_Segments", Segments, 7'h7F);
    step(6);  chk("t134_AN", AN, 4'hB); chk("t134_Segments", Segments, 7'b1000000);
    rst = 1'b1; wr_en = 1'b1; wr_data = 16'h9999;
    #1;
    chk("async_AN", AN, 4'hF); chk("async_Segments", Segments, 7'h7F);
    chk("async_bp", bp, 1'b1); chk("async_wr_ack", wr_ack, 1'b0);
    chk("async_frame_done", frame_done, 1'b0);
    step(2);  chk("inrst_wr_ack", wr_ack, 1'b0); chk("inrst_AN", AN, 4'hF);
    rst = 1'b0; wr_en = 1'b0;
    step(1);  chk("re_t1_AN", AN, 4'hF);
    step(1);  chk("re_t2_AN", AN, 4'hE); chk("re_t2_Segments", Segments, 7'b1000000);
    step(6);  chk("re_t8_AN", AN, 4'hD); chk("re_t8_Segments", Segments, 7'b1000000);
    step(18);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
